// File: rtl/cool_attn_pkg.sv
// Shared types and defaults for the attention-path cluster wrappers.
//   LANES       : operand pairs per beat / multipliers per cluster
//   DATA_WIDTH  : default operand width per lane
//   PROD_WIDTH  : default cluster result width
//   lane_vec_t  : one beat's worth of lane operands, lane0 in LSBs
//   beat_tag_t  : per-slot marker that travels alongside the cluster pipeline
package cool_attn_pkg;

  localparam int unsigned LANES      = 8;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned PROD_WIDTH = 16;

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] lane_vec_t;

  typedef struct packed {
    logic valid;
    logic last;
  } beat_tag_t;

endpackage

// File: rtl/feeder_tag_line.sv
// Fixed-depth delay line of beat tags that runs in lockstep with a cluster
// pipeline: one tag enters per enabled cycle, everything freezes otherwise.
//   clk, rst : clock, asynchronous active-high reset (clears every stage)
//   en_i     : advance the line by one stage
//   tag_i    : tag entering stage 0
//   tag_o    : tag held in the last stage
module feeder_tag_line
  import cool_attn_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en_i,
  input  beat_tag_t tag_i,
  output beat_tag_t tag_o
);

  beat_tag_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else if (en_i) begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mac_cluster_feeder.sv
// Feeds an 8-lane MAC cluster from a valid/ready beat stream and turns the
// per-beat cluster sums into one dot product per vector (beats closed by
// in_last).
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : beat handshake; in_a/in_b lane operands, in_last
//   cl_ebl, cl_a, cl_b  : cluster enable and operands (lane0 -> m1)
//   cl_out              : cluster sum, CLUSTER_LAT cycles after operand sample
//   res_valid/res_ready : result handshake; res_data dot product,
//                         res_beats beat count (saturating)
module mac_cluster_feeder #(
  parameter int unsigned DATA_WIDTH  = cool_attn_pkg::DATA_WIDTH,
  parameter int unsigned PROD_WIDTH  = cool_attn_pkg::PROD_WIDTH,
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned CLUSTER_LAT = 4,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [cool_attn_pkg::LANES*DATA_WIDTH-1:0]  in_a,
  input  logic [cool_attn_pkg::LANES*DATA_WIDTH-1:0]  in_b,
  input  logic                                        in_last,
  output logic                                        cl_ebl,
  output logic [cool_attn_pkg::LANES*DATA_WIDTH-1:0]  cl_a,
  output logic [cool_attn_pkg::LANES*DATA_WIDTH-1:0]  cl_b,
  input  logic [PROD_WIDTH-1:0]                       cl_out,
  output logic                                        res_valid,
  input  logic                                        res_ready,
  output logic [ACC_WIDTH-1:0]                        res_data,
  output logic [CNT_WIDTH-1:0]                        res_beats
);

  import cool_attn_pkg::*;

  logic                 accept;
  beat_tag_t            push_tag;
  beat_tag_t            line_tag;
  beat_tag_t            exit_q;

  logic [ACC_WIDTH-1:0] acc_q,       acc_d;
  logic [CNT_WIDTH-1:0] cnt_q,       cnt_d;
  logic                 res_valid_q, res_valid_d;
  logic [ACC_WIDTH-1:0] res_data_q,  res_data_d;
  logic [CNT_WIDTH-1:0] res_beats_q, res_beats_d;

  logic [ACC_WIDTH-1:0] acc_sum;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // A held result that is not being taken freezes the whole pipeline, so
  // the next last-exit can never collide with an unconsumed result.
  assign cl_ebl   = !(res_valid_q && !res_ready) && !rst;
  assign in_ready = cl_ebl;
  assign accept   = in_valid && cl_ebl;

  // Idle slots carry zero operands so the cluster sum for a bubble is zero.
  assign cl_a = accept ? in_a : '0;
  assign cl_b = accept ? in_b : '0;

  assign push_tag.valid = accept;
  assign push_tag.last  = accept && in_last;

  feeder_tag_line #(
    .DEPTH (CLUSTER_LAT)
  ) u_tag_line (
    .clk   (clk),
    .rst   (rst),
    .en_i  (cl_ebl),
    .tag_i (push_tag),
    .tag_o (line_tag)
  );

  // exit_q is the tag leaving the line: it is captured on the same edge
  // that loads its beat's sum onto cl_out, so the two are paired here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exit_q <= '0;
    end else if (cl_ebl) begin
      exit_q <= line_tag;
    end
  end

  always_comb begin
    acc_sum     = acc_q + ACC_WIDTH'(cl_out);
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_beats_d = res_beats_q;

    if (cl_ebl) begin
      if (res_valid_q && res_ready) begin
        res_valid_d = 1'b0;
      end
      if (exit_q.valid) begin
        if (exit_q.last) begin
          res_valid_d = 1'b1;
          res_data_d  = acc_sum;
          res_beats_d = cnt_inc;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_beats_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_beats_q <= res_beats_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_beats = res_beats_q;

endmodule

// File: tb/tb_mac_cluster_feeder.sv
// Bench for mac_cluster_feeder: behavioural 8-lane cluster attached to the
// cl_* ports, a vector-level reference model feeding an expected-result
// queue, and an independent monitor that pops and compares on each result.
module tb_mac_cluster_feeder;

  localparam int DW  = 8;
  localparam int PW  = 16;
  localparam int AW  = 24;
  localparam int LAT = 4;
  localparam int CW  = 8;
  localparam int LB  = 8 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [LB-1:0] in_a, in_b;
  logic          cl_ebl;
  logic [LB-1:0] cl_a, cl_b;
  logic [PW-1:0] cl_out;
  logic          res_valid, res_ready;
  logic [AW-1:0] res_data;
  logic [CW-1:0] res_beats;

  always #5 clk = ~clk;

  mac_cluster_feeder #(
    .DATA_WIDTH  (DW),
    .PROD_WIDTH  (PW),
    .ACC_WIDTH   (AW),
    .CLUSTER_LAT (LAT),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .cl_ebl    (cl_ebl),
    .cl_a      (cl_a),
    .cl_b      (cl_b),
    .cl_out    (cl_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_beats (res_beats)
  );

  // Sum of lane products; the cluster output is PW bits wide, so this wraps.
  function automatic logic [PW-1:0] lane_dot(input logic [LB-1:0] a, input logic [LB-1:0] b);
    int unsigned s = 0;
    for (int i = 0; i < 8; i++) s += int'(a[i*DW +: DW]) * int'(b[i*DW +: DW]);
    return PW'(s);
  endfunction

  function automatic logic [LB-1:0] splat(input int unsigned v);
    logic [LB-1:0] r;
    for (int i = 0; i < 8; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  // Behavioural cluster: operands sampled on an enabled edge appear summed
  // on cl_out LAT enabled edges later.
  logic [PW-1:0] cm_q [0:LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LAT; i++) cm_q[i] <= '0;
    end else if (cl_ebl) begin
      cm_q[0] <= lane_dot(cl_a, cl_b);
      for (int i = 1; i <= LAT; i++) cm_q[i] <= cm_q[i-1];
    end
  end
  assign cl_out = cm_q[LAT];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  typedef struct {
    int unsigned data;
    int unsigned beats;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned m_acc = 0;
  int unsigned m_cnt = 0;

  // Vector-level reference: a result is the wrapped sum of its beats' cluster
  // sums plus a saturating beat count, produced when the last beat is taken.
  function automatic void model_accept(input logic [LB-1:0] a, input logic [LB-1:0] b,
                                       input logic last, input bit push);
    exp_t e;
    m_acc = (m_acc + int'(lane_dot(a, b))) % (1 << AW);
    m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
    if (last) begin
      e.data  = m_acc;
      e.beats = m_cnt;
      if (push) exp_q.push_back(e);
      m_acc = 0;
      m_cnt = 0;
    end
  endfunction

  function automatic void push_exp(input int unsigned d, input int unsigned n);
    exp_t e;
    e.data  = d;
    e.beats = n;
    exp_q.push_back(e);
  endfunction

  // res_ready policy, updated just after each rising edge.
  bit rr_rand  = 0;
  bit rr_force = 1;
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      res_ready = rr_rand ? ($urandom_range(3) != 0) : rr_force;
    end
  end

  // Monitor: every cycle a result is presented it must match the queue head;
  // it is popped when the handshake will complete on the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && res_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL res_unexpected got data=%0d beats=%0d exp=none", res_data, res_beats);
        end else begin
          chk("res_data", res_data, exp_q[0].data);
          chk("res_beats", res_beats, exp_q[0].beats);
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_beat(input logic [LB-1:0] a, input logic [LB-1:0] b,
                           input logic last, input bit push);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 500) break;
    end
    if (n > 500) begin
      chk("accept_timeout", n, 0);
    end else begin
      model_accept(a, b, last, push);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Assert reset with a live beat on the inputs; every output must drop at once.
  task automatic do_reset();
    in_valid = 1'b1;
    in_a     = splat(8'hAA);
    in_b     = splat(8'h55);
    rst      = 1'b1;
    exp_q.delete();
    m_acc = 0;
    m_cnt = 0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cl_ebl", cl_ebl, 0);
    chk("rst_cl_a", cl_a, 0);
    chk("rst_cl_b", cl_b, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_beats", res_beats, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LB-1:0] ramp;
    int unsigned   k, t0;

    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
    rst      = 1'b1;
    #1;
    do_reset();

    // Single beat, lanes a=1..8, b=1: 36, one beat, result after LAT+1 edges.
    for (int i = 0; i < 8; i++) ramp[i*DW +: DW] = DW'(i + 1);
    push_exp(36, 1);
    send_beat(ramp, splat(1), 1'b1, 0);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (res_valid && k == 0) k = i;
    end
    // First negedge after the accepting edge is i=1; edge t+LAT+1 -> i=LAT+2.
    chk("latency", k, LAT + 2);
    drain();

    // Two-beat vector: 8*2*3 + 8*1*1 = 56.
    push_exp(56, 2);
    send_beat(splat(2), splat(3), 1'b0, 0);
    send_beat(splat(1), splat(1), 1'b1, 0);
    drain();

    // Beats separated by idle cycles: 48 + 48 + 8 = 104, three beats.
    push_exp(104, 3);
    send_beat(splat(2), splat(3), 1'b0, 0);
    idle(3);
    send_beat(splat(2), splat(3), 1'b0, 0);
    idle(3);
    send_beat(splat(1), splat(1), 1'b1, 0);
    drain();

    // Backpressure: first result held for 5 cycles with the next vector in flight.
    rr_force = 0;
    idle(1);
    push_exp(8, 1);
    push_exp(48, 2);
    send_beat(splat(1), splat(1), 1'b1, 0);
    send_beat(splat(2), splat(2), 1'b0, 0);
    send_beat(splat(1), splat(2), 1'b1, 0);
    k = 0;
    while (!res_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp_wait_result", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_cl_ebl", cl_ebl, 0);
    end
    rr_force = 1;
    drain();

    // Back-to-back single-beat vectors of 255s; per-beat cluster sum wraps to PW bits.
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      push_exp((8 * 65025) % (1 << PW), 1);
      send_beat(splat(255), splat(255), 1'b1, 0);
    end
    chk("b2b_cycles", cyc - t0, 10);
    drain();

    // Long vector: beat count saturates and the accumulator wraps.
    for (int i = 0; i < 300; i++) send_beat(splat(255), splat(255), i == 299, 1);
    drain();

    // Reset in the middle of a vector, then a clean vector: 8*3*5 = 120.
    send_beat(splat(9), splat(9), 1'b0, 1);
    send_beat(splat(7), splat(7), 1'b0, 1);
    do_reset();
    push_exp(120, 1);
    send_beat(splat(3), splat(5), 1'b1, 0);
    drain();

    // Reset after the last beat was taken but before its result appears.
    send_beat(splat(4), splat(4), 1'b1, 1);
    idle(2);
    do_reset();
    send_beat(splat(6), splat(2), 1'b0, 1);
    send_beat(splat(1), splat(3), 1'b1, 1);
    drain();

    // Randomized traffic with random gaps and random result backpressure.
    rr_rand = 1;
    for (int i = 0; i < 250; i++) begin
      send_beat({$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(3) == 0), 1);
      if ($urandom_range(3) == 0) idle($urandom_range(2) + 1);
    end
    send_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1);
    drain();
    rr_rand = 0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
